ram8: RTL and testbench

- 8-word x 16-bit register file: the first sequential stage of the memory hierarchy.
- Consumes the combinational library directly:
  - dmux8way decodes `load` onto one of eight word registers.
  - mux8way16 selects the addressed word onto `out`.
- Building block for ram64/ram512 and the CPU data path.
- Nand2Tetris semantics: combinational read, clocked write.

---
 rtl/ram8_pkg.sv | 8 +
 rtl/dmux8way.sv | 15 +
 rtl/mux8way16.sv | 18 +
 rtl/register16.sv | 16 +
 rtl/ram8.sv | 38 +++
 tb/tb_ram8.sv | 83 ++++++++
 6 files changed

// File: rtl/ram8_pkg.sv
// ram8_pkg: shared widths, depth, reset word and word type for the ram8 register file
package ram8_pkg;
  localparam int WORD_W = 16;
  localparam int RAM8_ADDR_W = 3;
  localparam int RAM8_DEPTH = 8;
  localparam logic [15:0] RESET_WORD = 16'h0000;
  typedef logic [15:0] word_t;
endpackage

// File: rtl/dmux8way.sv
// dmux8way: routes in to one of a..h by sel (ports in, sel[2:0] -> a..h)
module dmux8way (
  input  logic       in,
  input  logic [2:0] sel,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       d,
  output logic       e,
  output logic       f,
  output logic       g,
  output logic       h
);
  assign {h, g, f, e, d, c, b, a} = {7'b0, in} << sel;
endmodule

// File: rtl/mux8way16.sv
// mux8way16: selects one of eight 16-bit inputs a..h by sel (ports a..h[15:0], sel[2:0] -> out[15:0])
module mux8way16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic [15:0] c,
  input  logic [15:0] d,
  input  logic [15:0] e,
  input  logic [15:0] f,
  input  logic [15:0] g,
  input  logic [15:0] h,
  input  logic [2:0]  sel,
  output logic [15:0] out
);
  always_comb begin
    out = sel[2] ? (sel[1] ? (sel[0] ? h : g) : (sel[0] ? f : e))
                 : (sel[1] ? (sel[0] ? d : c) : (sel[0] ? b : a));
  end
endmodule

// File: rtl/register16.sv
// register16: 16 load-enabled flops with sync reset priority (ports clk, rst, in[15:0], load -> out[15:0])
module register16 #(
  parameter logic [15:0] RESET_VAL = ram8_pkg::RESET_WORD
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] in,
  input  logic        load,
  output logic [15:0] out
);
  for (genvar i = 0; i < 16; i++) begin : g_bit
    always_ff @(posedge clk)
      if (rst) out[i] <= RESET_VAL[i];
      else if (load) out[i] <= in[i];
  end
endmodule

// File: rtl/ram8.sv
// ram8: 8x16 register file, clocked write, combinational read; RAM8_BYPASS_EN forwards in to out while load=1 (ports clk, rst, in[15:0], load, address[2:0] -> out[15:0])
module ram8
  import ram8_pkg::*;
#(
  parameter int          WIDTH     = WORD_W,
  parameter logic [15:0] RESET_VAL = RESET_WORD
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [WIDTH-1:0]       in,
  input  logic                   load,
  input  logic [RAM8_ADDR_W-1:0] address,
  output logic [WIDTH-1:0]       out
);
  word_t w [RAM8_DEPTH];
  word_t rd;
  logic [RAM8_DEPTH-1:0] ld;
  dmux8way u_dmux (
    .in(load), .sel(address),
    .a(ld[0]), .b(ld[1]), .c(ld[2]), .d(ld[3]),
    .e(ld[4]), .f(ld[5]), .g(ld[6]), .h(ld[7])
  );
  for (genvar k = 0; k < RAM8_DEPTH; k++) begin : g_word
    register16 #(.RESET_VAL(RESET_VAL)) u_reg (
      .clk(clk), .rst(rst), .in(in), .load(ld[k]), .out(w[k])
    );
  end
  mux8way16 u_mux (
    .a(w[0]), .b(w[1]), .c(w[2]), .d(w[3]),
    .e(w[4]), .f(w[5]), .g(w[6]), .h(w[7]),
    .sel(address), .out(rd)
  );
`ifdef RAM8_BYPASS_EN
  assign out = load ? in : rd;
`else
  assign out = rd;
`endif
endmodule

// File: tb/tb_ram8.sv
// tb_ram8: directed and random checks of ram8 against an 8-entry array model
module tb_ram8;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] in = '0;
  logic        load = 1'b0;
  logic [2:0]  address = '0;
  logic [15:0] out;
  logic [15:0] mem [8];
  int tests = 0;
  int fails = 0;

  ram8 dut (.clk(clk), .rst(rst), .in(in), .load(load), .address(address), .out(out));

  always #5 clk = ~clk;

  function automatic logic [15:0] expect_out();
`ifdef RAM8_BYPASS_EN
    if (load) return in;
`endif
    return mem[address];
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic r, input logic l, input logic [2:0] a, input logic [15:0] d, input string tag);
    rst = r; load = l; address = a; in = d;
    #1;
    chk({tag, "_pre"}, out, expect_out());
    @(posedge clk);
    if (r) for (int j = 0; j < 8; j++) mem[j] = 16'h0000;
    else if (l) mem[a] = d;
    #1;
    chk({tag, "_post"}, out, expect_out());
  endtask

  initial begin
    rst = 1'b1; load = 1'b1; in = 16'h1234;
    @(posedge clk);
    #1;
    for (int j = 0; j < 8; j++) mem[j] = 16'h0000;
    for (int k = 0; k < 8; k++) cyc(0, 0, 3'(k), 16'hCAFE, $sformatf("rst_sweep%0d", k));
    for (int k = 0; k < 8; k++) cyc(0, 1, 3'(k), 16'(16'h1111 * k), $sformatf("wr%0d", k));
    for (int k = 0; k < 8; k++) begin
      cyc(0, 0, 3'(k), 16'h0BAD, $sformatf("rd%0d", k));
      chk($sformatf("rd_const%0d", k), out, 16'(16'h1111 * k));
    end
    cyc(0, 1, 5, 16'hAAAA, "set5");
    rst = 0; load = 1; address = 5; in = 16'h5555;
    #1;
`ifdef RAM8_BYPASS_EN
    chk("rdw_before", out, 16'h5555);
`else
    chk("rdw_before", out, 16'hAAAA);
`endif
    @(posedge clk);
    mem[5] = 16'h5555;
    #1;
    chk("rdw_after", out, 16'h5555);
    cyc(0, 1, 2, 16'hFFFF, "iso_w2");
    for (int k = 0; k < 4; k++) begin
      cyc(0, 0, 3, 16'hDEAD, $sformatf("iso_hold%0d", k));
      chk($sformatf("iso_3333_%0d", k), out, 16'h3333);
    end
    cyc(0, 0, 2, 16'hDEAD, "iso_rd2");
    chk("iso_ffff", out, 16'hFFFF);
    cyc(1, 1, 4, 16'hBEEF, "rst_prio");
    for (int k = 0; k < 8; k++) begin
      cyc(0, 0, 3'(k), 16'hBEEF, $sformatf("prio_rd%0d", k));
      chk($sformatf("prio_zero%0d", k), out, 16'h0000);
    end
    for (int i = 0; i < 1000; i++)
      cyc($urandom_range(0, 49) == 0, 1'($urandom), 3'($urandom), 16'($urandom), $sformatf("rnd%0d", i));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
